pipe_controller: RTL
====================

# pipe_controller

Registered successor to the combinational main decoder. Decodes the ID-stage opcode into a packed control word and carries it, with the destination register, through the ID/EX, EX/MEM and MEM/WB control registers. Detects load-use hazards and branch/jump redirects, and inserts bubbles for both. Parametrised for register-index width, multi-cycle data-memory latency, and optional AUIPC support.

## Interface
Parameters:
- REG_ADDR_W, 5: register index width.
- MEM_WAIT, 0: extra cycles each load/store holds the MEM stage. Legal range 0..7.
- EN_AUIPC, 1: when 1, opcode 0010111 (AUIPC) decodes as legal. When 0 it decodes as illegal.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- Opcode  in  7  ID-stage opcode.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W  ID-stage register indices.
- ex_take_branch  in  1  EX resolved a taken branch or a jump.
- ex_ctrl, mem_ctrl, wb_ctrl  out  12  registered control words per stage.
- ex_rd, mem_rd, wb_rd  out  REG_ADDR_W  registered destination registers per stage.
- stall_id  out  1  hold PC and IF/ID this cycle.
- flush  out  1  squash IF/ID this cycle.
- mem_busy  out  1  MEM-stage wait in progress; whole pipeline frozen.
- illegal  out  1  ex_ctrl[11].

## Operation
Control word bit layout:
- [0] ALUSrc, [1] MemtoReg, [2] RegWrite, [3] MemRead, [4] MemWrite
- [6:5] ALUOp, [7] Branch, [8] JalSel, [9] JalrSel, [10] AuipcSel, [11] Illegal

Decode (when id_valid=1):
- R-type 0110011 = 0x044
- I-type 0010011 = 0x045
- LW 0000011 = 0x00F
- SW 0100011 = 0x011
- BEQ 1100011 = 0x0A0
- LUI 0110111 = 0x065
- JAL 1101111 = 0x1A4
- JALR 1100111 = 0x3A4
- AUIPC = 0x405
- Any other opcode = 0x800.
- id_valid=0 gives 0x000.
- RegWrite is cleared when id_rd=0.

Pipeline advance (mem_busy=0): wb<=mem, mem<=ex, and ex is loaded from one of:
- bubble (0x000, rd 0) if flush=1 or stall_id=1;
- otherwise the decoded ID word and id_rd.

Hazard outputs:
- Load-use: ex_ctrl[3]=1, ex_rd≠0, id_valid=1 and (ex_rd==id_rs1 or ex_rd==id_rs2) → stall_id=1. Both sources are compared for every opcode (conservative).
- flush = ex_take_branch & ~mem_busy.
- Flush has priority over load-use: when flush=1, load-use does not raise stall_id.

MEM wait FSM, states IDLE and WAIT, with a 3-bit counter cnt:
- IDLE→WAIT on an advancing edge that loads mem_ctrl with MemRead|MemWrite, when MEM_WAIT>0. Sets cnt=MEM_WAIT.
- In WAIT: mem_busy=1, stall_id=1, flush=0, and all stage registers hold.
- cnt decrements each cycle. At cnt=1 the next state is IDLE.
- A held access never re-enters WAIT. Back-to-back accesses each wait.
- MEM_WAIT=0: FSM stays in IDLE permanently.

## Timing
- Decode, stall_id, flush: combinational from inputs and registered state, same cycle.
- Control words: ID→EX 1 edge, EX→MEM 1 edge, MEM→WB 1 edge. This adds MEM_WAIT cycles per memory access.
- Reset: all ctrl/rd registers 0, FSM IDLE, cnt 0. stall_id, flush, mem_busy and illegal are forced 0 while reset=1.
- Reset mid-WAIT aborts the wait. Pipeline state clears on that edge.
- ex_take_branch during WAIT is ignored. Upstream keeps it asserted until the branch leaves EX.
- A load-use stall produces exactly one bubble. The dependent instruction enters EX on the following edge.

## Test plan
1. Reset for 2 cycles with R-type, id_rd=3, present → all outputs 0. After release, ex_ctrl=0x044 at +1 edge, mem_ctrl=0x044 at +2, wb_ctrl=0x044 at +3, wb_rd=3.
2. LW rd=5, then ADD rs1=5 → stall_id=1 for one cycle, ex_ctrl=0x000 next edge, ADD (0x044) in EX one edge later.
3. LW rd=5 in EX with ex_take_branch=1 while ADD rs2=5 is in ID → flush=1, stall_id=0, ex_ctrl=0x000 next edge.
4. MEM_WAIT=3, SW enters MEM (mem_ctrl=0x011) → mem_busy=1 for 3 cycles with all ctrl frozen. wb_ctrl=0x011 on the 4th edge. ex_take_branch asserted during the wait keeps flush=0.
5. Opcode 1111111 → ex_ctrl=0x800 and illegal=1 while in EX. ADDI with rd=0 → ex_ctrl=0x041.
6. EN_AUIPC=0 with opcode 0010111 → 0x800. EN_AUIPC=1 → 0x405. Reset asserted mid-WAIT → mem_busy=0 and all ctrl 0 after the edge.

Source files
------------

// File: rtl/pipe_controller.sv
// Registered pipeline control: decodes the ID opcode into a 12-bit control word,
// carries it through EX/MEM/WB, and handles load-use stalls, branch flushes and MEM waits.
module pipe_controller #(
    parameter int REG_ADDR_W = 5,
    parameter int MEM_WAIT   = 0,
    parameter bit EN_AUIPC   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            Opcode,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_take_branch,
    output logic [11:0]           ex_ctrl,
    output logic [11:0]           mem_ctrl,
    output logic [11:0]           wb_ctrl,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  stall_id,
    output logic                  flush,
    output logic                  mem_busy,
    output logic                  illegal
);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } mem_state_t;

    localparam logic [2:0] WAIT_CYC = 3'(MEM_WAIT);

    mem_state_t            r_state;
    mem_state_t            w_state_nxt;
    logic [2:0]            r_cnt;
    logic [2:0]            w_cnt_nxt;

    logic [11:0]           r_ex_ctrl;
    logic [11:0]           r_mem_ctrl;
    logic [11:0]           r_wb_ctrl;
    logic [REG_ADDR_W-1:0] r_ex_rd;
    logic [REG_ADDR_W-1:0] r_mem_rd;
    logic [REG_ADDR_W-1:0] r_wb_rd;

    logic [11:0]           w_dec;
    logic                  w_busy;
    logic                  w_take;
    logic                  w_load_use;
    logic                  w_bubble;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_dec = 12'h000;
        if (id_valid) begin
            case (Opcode)
                7'b0110011: w_dec = 12'h044;
                7'b0010011: w_dec = 12'h045;
                7'b0000011: w_dec = 12'h00F;
                7'b0100011: w_dec = 12'h011;
                7'b1100011: w_dec = 12'h0A0;
                7'b0110111: w_dec = 12'h065;
                7'b1101111: w_dec = 12'h1A4;
                7'b1100111: w_dec = 12'h3A4;
                7'b0010111: w_dec = EN_AUIPC ? 12'h405 : 12'h800;
                default:    w_dec = 12'h800;
            endcase
            if (id_rd == '0) begin
                w_dec[2] = 1'b0;
            end
        end
    end

    assign w_busy     = (r_state == ST_WAIT);
    assign w_take     = ex_take_branch & ~w_busy;
    // Both sources are compared regardless of opcode; a spurious stall only costs a cycle.
    assign w_load_use = r_ex_ctrl[3] & (r_ex_rd != '0) & id_valid &
                        ((r_ex_rd == id_rs1) | (r_ex_rd == id_rs2));
    assign w_bubble   = w_take | w_load_use;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_ctrl  <= '0;
            r_mem_ctrl <= '0;
            r_wb_ctrl  <= '0;
            r_ex_rd    <= '0;
            r_mem_rd   <= '0;
            r_wb_rd    <= '0;
        end else if (!w_busy) begin
            r_wb_ctrl  <= r_mem_ctrl;
            r_wb_rd    <= r_mem_rd;
            r_mem_ctrl <= r_ex_ctrl;
            r_mem_rd   <= r_ex_rd;
            r_ex_ctrl  <= w_bubble ? 12'h000 : w_dec;
            r_ex_rd    <= w_bubble ? '0 : id_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Entry looks at the word moving into MEM, so an access already held there cannot re-trigger.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if ((MEM_WAIT > 0) && (r_ex_ctrl[3] | r_ex_ctrl[4])) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = WAIT_CYC;
                end
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt - 3'd1;
                if (r_cnt <= 3'd1) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 3'd0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    assign ex_ctrl  = r_ex_ctrl;
    assign mem_ctrl = r_mem_ctrl;
    assign wb_ctrl  = r_wb_ctrl;
    assign ex_rd    = r_ex_rd;
    assign mem_rd   = r_mem_rd;
    assign wb_rd    = r_wb_rd;

    assign mem_busy = ~reset & w_busy;
    assign flush    = ~reset & w_take;
    assign stall_id = ~reset & (w_busy | (w_load_use & ~w_take));
    assign illegal  = ~reset & r_ex_ctrl[11];

endmodule
